// File: rtl/instr_fetch_unit.sv
// Fetch stage of the MIPS core: holds the PC, fetches one word per instruction over a
// req/ack port, presents it to the decoder until retirement, then steers the next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        mux_branch_jump,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] ins);
    jump_target = {pc4[31:28], ins[25:0], 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [31:0] ins);
    branch_target = pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
  endfunction

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-PC steering: jump beats a taken branch, which beats sequential flow
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (!mux_branch_jump) begin
      next_pc_s = jump_target(pc_plus4_s, instr_q);
    end else if (branch && alu_zero) begin
      next_pc_s = branch_target(pc_plus4_s, instr_q);
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // Output and datapath next values; only the input matching the current state acts
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      ST_RST: begin
        imem_req_d    = 1'b1;
        instr_valid_d = 1'b0;
        instr_d       = 32'd0;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end else begin
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          pc_d          = next_pc_s;
          retired_cnt_d = retired_cnt_q + 32'd1;
          instr_d       = 32'd0;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
        end else begin
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end
      end
      default: begin
        instr_d       = 32'd0;
        instr_valid_d = 1'b0;
        imem_req_d    = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops any outstanding request
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      retired_cnt_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized instruction streams,
// checked per instruction against a transaction-level PC/retirement model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] ADDI   = 32'h2108_0001;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done;
  logic        branch;
  logic        alu_zero;
  logic        mux_branch_jump;
  logic [31:0] retired_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .nrst(nrst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .ex_done(ex_done),
    .branch(branch), .alu_zero(alu_zero), .mux_branch_jump(mux_branch_jump),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule written as plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit mbj, input bit br, input bit z);
    int off;
    if (!mbj) begin
      model_next = ((cur + 32'd4) & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
    end else if (br && z) begin
      off = int'($signed(w[15:0]));
      model_next = cur + 32'd4 + 32'(off * 4);
    end else begin
      model_next = cur + 32'd4;
    end
  endfunction

  task automatic do_reset(input bit late_ack);
    nrst = 1'b0; imem_ack = late_ack; imem_rdata = $urandom; ex_done = 1'b0;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_cnt", retired_cnt, 32'd0);
    step();
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    nrst = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, RST_PC);
    chk("start_valid", {31'd0, instr_valid}, 32'd0);
    chk("start_instr", instr, 32'd0);
    exp_pc  = RST_PC;
    exp_cnt = 32'd0;
  endtask

  // One full instruction: fetch with wait states, execute, retire
  task automatic run_instr(input logic [31:0] word, input int waits, input int xwaits,
                           input bit mbj, input bit br, input bit z, input bit stray);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_instr", instr, 32'd0);
      imem_ack = 1'b0; imem_rdata = $urandom; ex_done = stray;
      step();
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack = 1'b1; imem_rdata = word; ex_done = stray;
    step();
    imem_ack = 1'b0; ex_done = 1'b0;
    chk("exec_instr", instr, word);
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc4", pc_plus4, exp_pc + 32'd4);
    chk("exec_cnt", retired_cnt, exp_cnt);
    for (int j = 0; j < xwaits; j++) begin
      imem_ack = stray; imem_rdata = $urandom; ex_done = 1'b0;
      step();
      chk("hold_instr", instr, word);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    ex_done = 1'b1; branch = br; alu_zero = z; mux_branch_jump = mbj;
    imem_ack = stray; imem_rdata = $urandom;
    step();
    ex_done = 1'b0; imem_ack = 1'b0;
    exp_pc  = model_next(exp_pc, word, mbj, br, z);
    exp_cnt = exp_cnt + 32'd1;
    chk("ret_req", {31'd0, imem_req}, 32'd1);
    chk("ret_addr", imem_addr, exp_pc);
    chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    chk("ret_instr", instr, 32'd0);
    chk("ret_cnt", retired_cnt, exp_cnt);
  endtask

  initial begin
    nrst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
    branch = 1'b0; alu_zero = 1'b0; mux_branch_jump = 1'b1;
    exp_pc = RST_PC; exp_cnt = 32'd0;

    do_reset(1'b0);
    for (int k = 0; k < 4; k++) run_instr(ADDI, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("seq_addr", imem_addr, 32'h0000_0010);
    chk("seq_cnt", retired_cnt, 32'd4);

    // reset while a request is outstanding, with a late ack
    do_reset(1'b1);
    run_instr(ADDI, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(ADDI, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("beq_taken", imem_addr, 32'h0000_0018);

    do_reset(1'b0);
    run_instr(ADDI, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(ADDI, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", imem_addr, 32'h0000_000C);

    do_reset(1'b0);
    run_instr(32'h0800_0400, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump_to_1000", imem_addr, 32'h0000_1000);
    run_instr(32'h0800_0040, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("jump_to_100", imem_addr, 32'h0000_0100);

    // wait states plus stray ack/ex_done in the wrong state
    run_instr(ADDI, 3, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("wait_next", imem_addr, 32'h0000_0104);

    // backward branch to the top of memory, then wrap to zero
    do_reset(1'b0);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    run_instr(ADDI, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_zero", imem_addr, 32'h0000_0000);

    for (int r = 0; r < 300; r++) begin
      run_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
